// File: rtl/seq_mult_n.sv
// Sequential shift-and-add multiplier: N-bit x N-bit -> registered 2N-bit product.
// Latency: start sampled at edge t0, done pulses in the cycle after edge t0+2N+1; period 2N+3.
// Backpressure: none; start is only looked at in IDLE, so requests while busy are dropped.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start             request, sampled in IDLE
//   a, b              operands (N bits), captured in LOAD
//   busy              high from LOAD through FIN
//   done              one-cycle pulse in FIN
//   p                 2N-bit product, updated on entry to FIN and held until the next FIN
//
// Build option: define MULT_SIGNED_EN for two's-complement operands and product.
module seq_mult_n #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     sumh_q, sumh_d;
    logic [N-1:0]     suml_q, suml_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   p_q, p_d;

    // Operand magnitudes fed to LOAD and the value captured into p.
    logic [N-1:0]     a_mag;
    logic [N-1:0]     b_mag;
    logic [2*N-1:0]   prod_shift;
    logic [2*N-1:0]   p_fin;

    // {C, SUMH, SUML} >> 1 with C refilled by zero; the dropped top bit is always 0.
    assign prod_shift = {c_q, sumh_q, suml_q[N-1:1]};

`ifdef MULT_SIGNED_EN
    logic sgn_q, sgn_d;

    // -2^(N-1) negates to itself, which read as unsigned is exactly its magnitude.
    assign a_mag = a[N-1] ? -a : a;
    assign b_mag = b[N-1] ? -b : b;
    assign p_fin = sgn_q ? -prod_shift : prod_shift;
`else
    assign a_mag = a;
    assign b_mag = b;
    assign p_fin = prod_shift;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        sumh_d  = sumh_q;
        suml_d  = suml_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        busy    = 1'b0;
        done    = 1'b0;
`ifdef MULT_SIGNED_EN
        sgn_d   = sgn_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                busy    = 1'b1;
                a_d     = a_mag;
                suml_d  = b_mag;
                sumh_d  = '0;
                c_d     = 1'b0;
                cnt_d   = '0;
`ifdef MULT_SIGNED_EN
                sgn_d   = a[N-1] ^ b[N-1];
`endif
                state_d = ADD;
            end
            ADD: begin
                busy = 1'b1;
                if (suml_q[0]) begin
                    {c_d, sumh_d} = {1'b0, sumh_q} + {1'b0, a_q};
                end else begin
                    c_d = 1'b0;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                busy                    = 1'b1;
                {c_d, sumh_d, suml_d}   = {1'b0, prod_shift};
                cnt_d                   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // Capture uses the post-shift value so p is final on entry to FIN.
                    p_d     = p_fin;
                    state_d = FIN;
                end else begin
                    state_d = ADD;
                end
            end
            FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            sumh_q  <= '0;
            suml_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
`ifdef MULT_SIGNED_EN
            sgn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            sumh_q  <= sumh_d;
            suml_q  <= suml_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
`ifdef MULT_SIGNED_EN
            sgn_q   <= sgn_d;
`endif
        end
    end

    assign p = p_q;

endmodule

// File: tb/tb_seq_mult_n.sv
module tb_seq_mult_n;

    logic        clk;
    logic        reset;
    logic        start8, start16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy8, done8, busy16, done16;
    logic [15:0] p8;
    logic [31:0] p16;

    int n_checks = 0;
    int n_fail   = 0;

    seq_mult_n #(.N(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .p     (p8)
    );

    seq_mult_n #(.N(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .busy  (busy16),
        .done  (done16),
        .p     (p16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observes one operation from the current cycle (index cyc_start) until busy drops.
    // Returns the number of busy cycles, the cycle index of done, the number of done
    // cycles, p during done and p in the first idle cycle after.
    task automatic run_op(input bit wide, input int cyc_start,
                          output int busy_cnt, output int done_at, output int done_cnt,
                          output logic [31:0] p_done, output logic [31:0] p_idle);
        logic        b_now, d_now;
        logic [31:0] p_now;
        busy_cnt = 0;
        done_at  = -1;
        done_cnt = 0;
        p_done   = 32'hDEAD_BEEF;
        p_idle   = 32'hDEAD_BEEF;
        for (int cyc = cyc_start; cyc < cyc_start + 80; cyc++) begin
            if (wide) begin
                b_now = busy16; d_now = done16; p_now = p16;
            end else begin
                b_now = busy8;  d_now = done8;  p_now = {16'h0, p8};
            end
            if (!b_now) begin
                p_idle = p_now;
                break;
            end
            busy_cnt++;
            if (d_now) begin
                done_cnt++;
                done_at = cyc;
                p_done  = p_now;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start8 = 1'b0; start16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        step();
        step();
        n_checks++;
        if ({busy8, done8, p8} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_n8: busy=%0b done=%0b p=%0h, required all 0", busy8, done8, p8);
        end
        n_checks++;
        if ({busy16, done16, p16} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_n16: busy=%0b done=%0b p=%0h, required all 0", busy16, done16, p16);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%0b, required 0", busy8);
        end
    endtask

    // One-cycle start on the chosen DUT, then latency, busy width, done width and product.
    task automatic test_product(input string name, input bit wide,
                                input logic [15:0] av, input logic [15:0] bv,
                                input logic [31:0] exp_p, input int exp_lat);
        int bc, da, dc;
        logic [31:0] pd, pi;
        if (wide) begin
            a16 = av; b16 = bv; start16 = 1'b1;
        end else begin
            a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1;
        end
        step();
        start8 = 1'b0; start16 = 1'b0;
        run_op(wide, 0, bc, da, dc, pd, pi);
        n_checks++;
        if (da !== exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: done after %0d cycles, required %0d", name, da, exp_lat);
        end
        n_checks++;
        if (bc !== exp_lat + 1) begin
            n_fail++;
            $display("FAIL %s_busy_width: busy %0d cycles, required %0d", name, bc, exp_lat + 1);
        end
        n_checks++;
        if (dc !== 1) begin
            n_fail++;
            $display("FAIL %s_done_width: done %0d cycles, required 1", name, dc);
        end
        n_checks++;
        if (pd !== exp_p) begin
            n_fail++;
            $display("FAIL %s_product: p=%0h, required %0h", name, pd, exp_p);
        end
        n_checks++;
        if (pi !== exp_p) begin
            n_fail++;
            $display("FAIL %s_hold: p after done=%0h, required %0h", name, pi, exp_p);
        end
    endtask

    task automatic test_basic();
        test_product("mul13x11", 1'b0, 16'd13, 16'd11, 32'h008F, 17);
    endtask

    task automatic test_extremes();
`ifdef MULT_SIGNED_EN
        test_product("neg3x5",      1'b0, 16'h00FD, 16'h0005, 32'h0000_FFF1, 17);
        test_product("min_x_min",   1'b0, 16'h0080, 16'h0080, 32'h0000_4000, 17);
        test_product("max_x_neg1",  1'b0, 16'h007F, 16'h00FF, 32'h0000_FF81, 17);
`else
        test_product("mul255x255",  1'b0, 16'd255, 16'd255, 32'h0000_FE01, 17);
        test_product("mul0x200",    1'b0, 16'd0,   16'd200, 32'h0000_0000, 17);
`endif
    endtask

    // start held high: the first run must finish before the second is sampled, and
    // operand changes after LOAD must not disturb the first result.
    task automatic test_back_to_back();
        int bc, da, dc;
        logic [31:0] pd, pi;
        a8 = 8'd3; b8 = 8'd4; start8 = 1'b1;
        step();              // sampling edge t0, LOAD now
        step();              // operands captured, ADD now
        a8 = 8'd5; b8 = 8'd6;
        run_op(1'b0, 1, bc, da, dc, pd, pi);
        n_checks++;
        if (da !== 17 || pd !== 32'd12) begin
            n_fail++;
            $display("FAIL held_first: done at %0d p=%0d, required 17 and 12", da, pd);
        end
        n_checks++;
        if (bc !== 17 || dc !== 1) begin
            n_fail++;
            $display("FAIL held_first_busy: busy %0d done %0d, required 17 and 1", bc, dc);
        end
        // Now in IDLE with start still high; the next edge samples it.
        step();
        start8 = 1'b0;
        run_op(1'b0, 0, bc, da, dc, pd, pi);
        n_checks++;
        if (da !== 17 || pd !== 32'd30) begin
            n_fail++;
            $display("FAIL held_second: done at %0d p=%0d, required 17 and 30", da, pd);
        end
        n_checks++;
        if (bc !== 18) begin
            n_fail++;
            $display("FAIL held_second_busy: busy %0d cycles, required 18", bc);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
        step();
        start8 = 1'b0;
        repeat (8) step();   // SHIFT of the 4th iteration
        n_checks++;
        if (busy8 !== 1'b1 || p8 !== 16'd30) begin
            n_fail++;
            $display("FAIL pre_abort: busy=%0b p=%0d, required 1 and 30", busy8, p8);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy8, done8, p8} !== 18'h0) begin
            n_fail++;
            $display("FAIL abort_clear: busy=%0b done=%0b p=%0h, required all 0", busy8, done8, p8);
        end
        step();
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (done8 || busy8 || p8 != 16'd0) done_seen++;
            step();
        end
        n_checks++;
        if (done_seen !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d cycles with activity after abort, required 0", done_seen);
        end
        test_product("after_abort_7x9", 1'b0, 16'd7, 16'd9, 32'd63, 17);
    endtask

    task automatic test_wide();
`ifdef MULT_SIGNED_EN
        test_product("n16_neg1x2", 1'b1, 16'hFFFF, 16'h0002, 32'hFFFF_FFFE, 33);
`else
        test_product("n16_ffffx2", 1'b1, 16'hFFFF, 16'h0002, 32'h0001_FFFE, 33);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult_n.md
# seq_mult_n

Parametrised sequential shift-and-add multiplier: control FSM plus datapath (A, SUMH/SUML accumulator, carry C, iteration counter) in one block, generalised to N-bit operands. It produces a registered 2N-bit product with a start/busy/done handshake. It replaces the fixed-width control unit with its separate datapath in the multiplier system. Signed two's-complement operation is an optional build feature.

## Interface
- N, 8, operand width in bits; legal range 2..32.
- clk  in  1  clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- start  in  1  request; sampled only in IDLE.
- a  in  N  multiplicand; captured in LOAD.
- b  in  N  multiplier; captured in LOAD.
- busy  out  1  high in LOAD, ADD, SHIFT, FIN; low in IDLE.
- done  out  1  one-cycle pulse, high only in FIN.
- p  out  2N  product register; valid from the FIN cycle and held until the next FIN.

## Operation
- Registers:
  - A[N-1:0]
  - SUMH[N-1:0]
  - SUML[N-1:0]
  - C (1 bit)
  - cnt[$clog2(N)-1:0]
  - sgn (1 bit, signed build only)
  - p[2N-1:0]
- FSM states: IDLE, LOAD, ADD, SHIFT, FIN. State register is updated on clk; next-state and control decode are combinational with default-zero outputs.
- IDLE: if start = 1, go to LOAD; otherwise stay in IDLE.
- LOAD:
  - A <= a; SUML <= b; SUMH <= 0; C <= 0; cnt <= 0.
  - Go to ADD.
- ADD:
  - If SUML[0] = 1: {C, SUMH} <= SUMH + A (N+1-bit sum).
  - Otherwise: C <= 0 and SUMH is unchanged.
  - Go to SHIFT.
- SHIFT:
  - {C, SUMH, SUML} <= {C, SUMH, SUML} >> 1, with C refilled with 0.
  - cnt <= cnt + 1.
  - If cnt == N-1 before the increment, go to FIN; otherwise go to ADD.
- Product capture: p <= {SUMH, SUML} is loaded on the SHIFT->FIN edge, using the shifted value. This value is exact; no overflow is possible.
- FIN: done = 1; go to IDLE unconditionally. start in FIN is ignored.
- start while busy is ignored; a and b may change freely after LOAD.
- Reset mid-operation:
  - Next state IDLE.
  - busy = 0, done = 0, p = 0.
  - The aborted result is never presented.
- Reset values: busy 0, done 0, p 0, and all internal registers 0.

## Timing
- Latency:
  - start is sampled at edge t0; LOAD runs in cycle t0+1.
  - Then N ADD/SHIFT pairs.
  - FIN, with done high, runs in the cycle after edge t0 + 2N+1.
- For N = 8, done is high 17 cycles after the sampling edge.
- p changes at the same edge that raises done and is stable for the whole done cycle.
- Back-to-back throughput: the earliest next start sample is the edge leaving FIN (IDLE entered) plus one. Minimum period is 2N+3 cycles.
- busy rises one edge after start is sampled and falls at the edge FIN -> IDLE.

## Configuration
- MULT_SIGNED_EN defined: a and b are two's complement.
  - LOAD stores |a| in A and |b| in SUML, as N-bit unsigned values. -2^(N-1) maps to 2^(N-1).
  - LOAD sets sgn <= a[N-1] ^ b[N-1].
  - At capture, p <= sgn ? -{SUMH, SUML} : {SUMH, SUML}, as a 2N-bit two's-complement value.
  - Latency is unchanged.
- MULT_SIGNED_EN undefined: a and b are unsigned, and sgn and the negation logic are absent.

## Test plan
- N=8, unsigned: a=13, b=11, one-cycle start -> done pulse 17 cycles later, p=0x008F; busy high for exactly 18 cycles.
- N=8, unsigned: a=255, b=255 -> p=0xFE01; separately, a=0, b=200 -> p=0x0000. Latency is identical for both.
- start held high continuously with a=3, b=4, then a=5, b=6 presented mid-run -> first result p=12; the second run starts only after FIN -> IDLE and yields 30; no start is sampled while busy.
- Reset asserted during SHIFT of the 4th iteration -> busy=0, done=0, p=0 immediately; a following start with a=7, b=9 gives p=63 with normal latency.
- MULT_SIGNED_EN, N=8:
  - a=-3 (0xFD), b=5 -> p=0xFFF1.
  - a=-128, b=-128 -> p=0x4000.
  - a=127, b=-1 -> p=0xFF81.
- N=16, unsigned: a=0xFFFF, b=0x0002 -> p=0x0001FFFE with done 33 cycles after start.
